// File: rtl/spi_host_pkg.sv
// spi_host register map shared with the software headers.
// Register indices decode apbs_paddr[3:2]; bit positions are CSR fields.
package spi_host_pkg;

    typedef enum logic [1:0] {
        REG_CSR = 2'd0,
        REG_DIV = 2'd1,
        REG_TX  = 2'd2,
        REG_RX  = 2'd3
    } reg_idx_t;

    localparam int CSR_BUSY   = 0;
    localparam int CSR_CPOL   = 1;
    localparam int CSR_CPHA   = 2;
    localparam int CSR_CSAUTO = 3;
    localparam int CSR_CS     = 4;
    localparam int CSR_IRQ_EN = 8;
    localparam int CSR_DONE   = 9;

endpackage

// File: rtl/spi_host_regs.sv
// APB register block for spi_host: CSR, DIV, TX strobe and RX.
// Configuration fields are frozen while the engine reports busy.
module spi_host_regs
    import spi_host_pkg::*;
#(
    parameter int W_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             apbs_psel,
    input  logic             apbs_penable,
    input  logic             apbs_pwrite,
    input  logic [15:0]      apbs_paddr,
    input  logic [31:0]      apbs_pwdata,
    output logic [31:0]      apbs_prdata,
    input  logic             busy,
    input  logic             done_set,
    input  logic [7:0]       rx_data,
    output logic             cpol,
    output logic             cpha,
    output logic             csauto,
    output logic             cs,
    output logic             irq_en,
    output logic             done,
    output logic [W_DIV-1:0] div,
    output logic             tx_start,
    output logic [7:0]       tx_data
);

    reg_idx_t   idx;
    logic       wr;
    logic       wr_csr;
    logic       wr_div;
    logic [7:0] rx;
    logic       unused_ok;

    assign idx      = reg_idx_t'(apbs_paddr[3:2]);
    assign wr       = apbs_psel & apbs_penable & apbs_pwrite;
    assign wr_csr   = wr && (idx == REG_CSR);
    assign wr_div   = wr && (idx == REG_DIV);
    assign tx_start = wr && (idx == REG_TX) && !busy;
    assign tx_data  = apbs_pwdata[7:0];
    assign unused_ok = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol   <= 1'b0;
            cpha   <= 1'b0;
            csauto <= 1'b1;
            cs     <= 1'b0;
            irq_en <= 1'b0;
            done   <= 1'b0;
            div    <= W_DIV'(1);
            rx     <= '0;
        end else begin
            if (wr_csr && !busy) begin
                cpol   <= apbs_pwdata[CSR_CPOL];
                cpha   <= apbs_pwdata[CSR_CPHA];
                csauto <= apbs_pwdata[CSR_CSAUTO];
                cs     <= apbs_pwdata[CSR_CS];
            end
            if (wr_csr)
                irq_en <= apbs_pwdata[CSR_IRQ_EN];
            // a completing transfer beats a simultaneous clear
            if (done_set)
                done <= 1'b1;
            else if (wr_csr && apbs_pwdata[CSR_DONE])
                done <= 1'b0;
            if (wr_div && !busy)
                div <= apbs_pwdata[W_DIV-1:0];
            if (done_set)
                rx <= rx_data;
        end
    end

    always_comb begin
        apbs_prdata = '0;
        if (apbs_psel) begin
            unique case (idx)
                REG_CSR: begin
                    apbs_prdata[CSR_BUSY]   = busy;
                    apbs_prdata[CSR_CPOL]   = cpol;
                    apbs_prdata[CSR_CPHA]   = cpha;
                    apbs_prdata[CSR_CSAUTO] = csauto;
                    apbs_prdata[CSR_CS]     = cs;
                    apbs_prdata[CSR_IRQ_EN] = irq_en;
                    apbs_prdata[CSR_DONE]   = done;
                end
                REG_DIV: apbs_prdata[W_DIV-1:0] = div;
                REG_TX:  apbs_prdata = '0;
                REG_RX:  apbs_prdata[7:0] = rx;
            endcase
        end
    end

endmodule

// File: rtl/spi_host.sv
// Single-byte SPI host: transfer FSM, half-period divider and shifter.
// Registers and APB decode live in spi_host_regs.
module spi_host
    import spi_host_pkg::*;
#(
    parameter int W_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic             cpol, cpha, csauto, cs, irq_en, done;
    logic [W_DIV-1:0] div;
    logic [W_DIV-1:0] h_m1;
    logic [W_DIV-1:0] cnt;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [7:0]       shreg;
    logic [4:0]       ecnt;
    logic             sck, mosi;
    logic             busy, last, edge_now, done_set;

    spi_host_regs #(.W_DIV(W_DIV)) u_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_psel    (apbs_psel),
        .apbs_penable (apbs_penable),
        .apbs_pwrite  (apbs_pwrite),
        .apbs_paddr   (apbs_paddr),
        .apbs_pwdata  (apbs_pwdata),
        .apbs_prdata  (apbs_prdata),
        .busy         (busy),
        .done_set     (done_set),
        .rx_data      (shreg),
        .cpol         (cpol),
        .cpha         (cpha),
        .csauto       (csauto),
        .cs           (cs),
        .irq_en       (irq_en),
        .done         (done),
        .div          (div),
        .tx_start     (tx_start),
        .tx_data      (tx_data)
    );

    assign h_m1     = (div == '0) ? '0 : div - W_DIV'(1);
    assign last     = (cnt == h_m1);
    assign busy     = (state != S_IDLE);
    assign edge_now = last && ((state == S_SETUP) ||
                      ((state == S_SHIFT) && (ecnt != 5'd16)));
    assign done_set = last && (state == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ecnt  <= '0;
            shreg <= '0;
            sck   <= 1'b0;
            mosi  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    sck <= cpol;
                    cnt <= '0;
                    if (tx_start) begin
                        state <= S_SETUP;
                        ecnt  <= '0;
                        shreg <= tx_data;
                        if (!cpha)
                            mosi <= tx_data[7];
                    end
                end
                S_SETUP: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                S_SHIFT: begin
                    if (last) begin
                        cnt <= '0;
                        if (ecnt == 5'd16)
                            state <= S_HOLD;
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                S_HOLD: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
            endcase
            // even ecnt is a leading edge; sample edge parity follows CPHA
            if (edge_now) begin
                sck  <= ~sck;
                ecnt <= ecnt + 5'd1;
                if (ecnt[0] == cpha)
                    shreg <= {shreg[6:0], spi_miso};
                else if (ecnt != 5'd15)
                    mosi <= shreg[7];
            end
        end
    end

    assign spi_sck      = sck;
    assign spi_mosi     = mosi;
    assign spi_cs_n     = !((busy & csauto) | cs);
    assign irq          = done & irq_en;
    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;

endmodule

// File: tb/tb_spi_host.sv
// Scoreboard bench for spi_host: APB driver, SPI slave/loopback model,
// expected RX bytes queued at TX write and checked on completion.
module tb_spi_host;

    localparam logic [15:0] A_CSR = 16'h0;
    localparam logic [15:0] A_DIV = 16'h4;
    localparam logic [15:0] A_TX  = 16'h8;
    localparam logic [15:0] A_RX  = 16'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        apbs_psel = 1'b0;
    logic        apbs_penable = 1'b0;
    logic        apbs_pwrite = 1'b0;
    logic [15:0] apbs_paddr = '0;
    logic [31:0] apbs_pwdata = '0;
    logic [31:0] apbs_prdata;
    logic        apbs_pready;
    logic        apbs_pslverr;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       mosi_q[$];
    time        edge_q[$];
    logic       cap_en = 1'b0;
    logic       loopback = 1'b0;
    logic [7:0] slv_byte = 8'h00;
    int         slv_idx = 0;
    logic       cs_mon = 1'b0;
    int         cs_hi = 0;

    always #5 clk = ~clk;

    spi_host #(.W_DIV(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_psel    (apbs_psel),
        .apbs_penable (apbs_penable),
        .apbs_pwrite  (apbs_pwrite),
        .apbs_paddr   (apbs_paddr),
        .apbs_pwdata  (apbs_pwdata),
        .apbs_prdata  (apbs_prdata),
        .apbs_pready  (apbs_pready),
        .apbs_pslverr (apbs_pslverr),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .irq          (irq)
    );

    // mode-0 slave: bit7 at CS assertion, next bit after each falling SCK
    always @(negedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n)
            slv_idx <= 0;
        else
            slv_idx <= slv_idx + 1;
    end

    always_comb begin
        spi_miso = 1'b0;
        if (loopback)
            spi_miso = spi_mosi;
        else if (slv_idx < 8)
            spi_miso = slv_byte[7-slv_idx];
    end

    always @(posedge spi_sck)
        if (cap_en && !spi_cs_n)
            mosi_q.push_back(spi_mosi);

    always @(spi_sck)
        if (cap_en && !spi_cs_n)
            edge_q.push_back($time);

    always @(negedge clk)
        if (cs_mon && spi_cs_n)
            cs_hi <= cs_hi + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
        apbs_psel    = 1'b1;
        apbs_pwrite  = 1'b1;
        apbs_paddr   = a;
        apbs_pwdata  = d;
        apbs_penable = 1'b0;
        @(negedge clk);
        apbs_penable = 1'b1;
        @(negedge clk);
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
        apbs_pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [15:0] a, output logic [31:0] d);
        apbs_psel    = 1'b1;
        apbs_pwrite  = 1'b0;
        apbs_paddr   = a;
        apbs_penable = 1'b0;
        @(negedge clk);
        apbs_penable = 1'b1;
        #1 d = apbs_prdata;
        @(negedge clk);
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
    endtask

    // counts cycles with BUSY set, observed through CSR setup-phase reads
    task automatic wait_idle(output int n);
        apbs_psel    = 1'b1;
        apbs_pwrite  = 1'b0;
        apbs_paddr   = A_CSR;
        apbs_penable = 1'b0;
        n = 0;
        while (n < 2000) begin
            #1;
            if (!apbs_prdata[0])
                break;
            n++;
            @(negedge clk);
        end
        apbs_psel = 1'b0;
        if (n >= 2000)
            chk("idle_timeout", 32'(n), 0);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] rx_exp,
                        input int len);
        int          n;
        logic [31:0] d;
        apb_wr(A_TX, {24'h0, tx});
        exp_q.push_back(rx_exp);
        wait_idle(n);
        if (len > 0)
            chk("busy_len", 32'(n), 32'(len));
        apb_rd(A_RX, d);
        chk("rx", d, {24'h0, exp_q.pop_front()});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  pat;
        int          n;
        int          bad;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_sck", 32'(spi_sck), 0);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_prdata", apbs_prdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        apb_rd(A_CSR, d);
        chk("rst_csr", d, 32'h8);
        apb_rd(A_DIV, d);
        chk("rst_div", d, 32'h1);
        apb_rd(A_RX, d);
        chk("rst_rx", d, 32'h0);

        // mode 0, DIV=1, slave answers 0x3C
        pat = 8'hA5;
        slv_byte = 8'h3C;
        mosi_q.delete();
        cap_en = 1'b1;
        xfer(pat, 8'h3C, 18);
        cap_en = 1'b0;
        chk("mosi_count", 32'(mosi_q.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < mosi_q.size())
                chk("mosi_bit", 32'(mosi_q[i]), 32'(pat[7-i]));
        chk("mosi_hold", 32'(spi_mosi), 1);
        chk("cs_n_after", 32'(spi_cs_n), 1);
        apb_rd(A_CSR, d);
        chk("csr_done", d, 32'h208);
        apb_wr(A_CSR, 32'h208);

        // mode 3, DIV=4, loopback
        apb_wr(A_CSR, 32'h00E);
        @(negedge clk);
        chk("sck_idle_hi", 32'(spi_sck), 1);
        apb_wr(A_DIV, 32'h4);
        loopback = 1'b1;
        edge_q.delete();
        cap_en = 1'b1;
        xfer(8'hFF, 8'hFF, 72);
        cap_en = 1'b0;
        chk("edge_count", 32'(edge_q.size()), 16);
        bad = 0;
        for (int i = 1; i < edge_q.size(); i++)
            if (edge_q[i] - edge_q[i-1] != 40)
                bad++;
        chk("half_period", 32'(bad), 0);
        chk("sck_idle_end", 32'(spi_sck), 1);
        apb_wr(A_CSR, 32'h208);
        apb_wr(A_DIV, 32'h1);

        // manual CS held across two bytes
        apb_wr(A_CSR, 32'h210);
        chk("cs_manual", 32'(spi_cs_n), 0);
        cs_mon = 1'b1;
        xfer(8'h5A, 8'h5A, 18);
        xfer(8'hC3, 8'hC3, 18);
        cs_mon = 1'b0;
        chk("cs_gap", 32'(cs_hi), 0);
        apb_wr(A_CSR, 32'h200);
        chk("cs_release", 32'(spi_cs_n), 1);

        // TX and DIV writes while busy are dropped
        apb_wr(A_CSR, 32'h208);
        apb_wr(A_TX, 32'h81);
        exp_q.push_back(8'h81);
        apb_wr(A_DIV, 32'h7);
        apb_wr(A_TX, 32'h18);
        wait_idle(n);
        chk("busy_len_wr", 32'(n), 14);
        apb_rd(A_RX, d);
        chk("rx_busy_wr", d, {24'h0, exp_q.pop_front()});
        apb_rd(A_DIV, d);
        chk("div_kept", d, 32'h1);

        // interrupt and W1C
        apb_wr(A_CSR, 32'h308);
        chk("irq_low", 32'(irq), 0);
        xfer(8'h66, 8'h66, 18);
        chk("irq_rise", 32'(irq), 1);
        apb_wr(A_CSR, 32'h308);
        chk("irq_drop", 32'(irq), 0);

        // W1C access lands on the cycle DONE is set
        apb_wr(A_TX, 32'h99);
        exp_q.push_back(8'h99);
        repeat (16) @(negedge clk);
        apb_wr(A_CSR, 32'h308);
        chk("done_wins_irq", 32'(irq), 1);
        apb_rd(A_CSR, d);
        chk("done_wins_csr", d, 32'h308);
        apb_rd(A_RX, d);
        chk("rx_coinc", d, {24'h0, exp_q.pop_front()});
        apb_wr(A_CSR, 32'h208);

        // reset in the middle of SHIFT
        apb_wr(A_DIV, 32'h4);
        apb_wr(A_TX, 32'h3C);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(spi_cs_n), 1);
        chk("mid_rst_sck", 32'(spi_sck), 0);
        chk("mid_rst_irq", 32'(irq), 0);
        apbs_psel  = 1'b1;
        apbs_paddr = A_CSR;
        #1;
        chk("mid_rst_busy", 32'(apbs_prdata[0]), 0);
        apbs_psel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apb_rd(A_RX, d);
        chk("rx_no_partial", d, 32'h0);
        xfer(8'h96, 8'h96, 18);
        apb_rd(A_CSR, d);
        chk("csr_after_rst", d, 32'h208);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_host.md
# spi_host

Single-byte SPI host controller on the peripheral APB bus. It drives the `spi_cs_n`, `spi_sck` and `spi_mosi` alternate-function inputs of the GPIO block and consumes its `spi_miso` output, which is the raw, unsynchronised MISO pad input. Software configures clock mode and divider, writes a byte to start a transfer, then polls or takes an interrupt for the received byte.

## Interface
- `W_DIV`, 8: width of clock divider field.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `apbs_psel`, `apbs_penable`, `apbs_pwrite` in 1: APB control.
- `apbs_paddr` in 16: APB address; bits [3:2] decoded, others ignored.
- `apbs_pwdata` in 32: APB write data.
- `apbs_prdata` out 32: APB read data.
- `apbs_pready` out 1: tied 1.
- `apbs_pslverr` out 1: tied 0.
- `spi_cs_n` out 1: chip select, to GPIO.
- `spi_sck` out 1: serial clock, to GPIO.
- `spi_mosi` out 1: serial data out, to GPIO.
- `spi_miso` in 1: serial data in, from GPIO.
- `irq` out 1: level interrupt, `CSR.DONE & CSR.IRQ_EN`.

## Operation
- Registers:
  - 0x0 CSR: [0] BUSY (RO); [1] CPOL; [2] CPHA; [3] CSAUTO (reset 1); [4] CS (manual CS level, reset 0 = deasserted); [8] IRQ_EN; [9] DONE (W1C).
  - 0x4 DIV: [W_DIV-1:0]; half-period H = max(DIV,1) clk cycles; reset 1.
  - 0x8 TX: write of [7:0] starts a transfer; reads 0.
  - 0xC RX: [7:0] last received byte; RO.
- While BUSY, writes to CPOL, CPHA, CSAUTO, CS, DIV and TX are ignored. IRQ_EN and DONE writes still take effect.
- FSM states and durations:
  - IDLE → SETUP: on TX write. Shift register loaded; CS asserted if CSAUTO. Lasts H.
  - SETUP → SHIFT: 16 SCK edges, one every H cycles.
  - SHIFT → HOLD: lasts H; CS released at its end if CSAUTO.
  - HOLD → IDLE: sets DONE and loads RX.
- Chip select: `spi_cs_n` = !(BUSY&CSAUTO | CS).
- Bit order MSB first.
- Edge usage, CPHA=0:
  - MOSI bit7 presented from SETUP entry.
  - MISO sampled on odd (leading) edges.
  - MOSI shifts on even (trailing) edges.
- Edge usage, CPHA=1:
  - MOSI shifts on leading edges.
  - MISO sampled on trailing edges.
- SCK idles at CPOL; changing CPOL in IDLE moves `spi_sck` on the next cycle.
- MISO is captured into the shift register on the same clk edge that registers the sampling SCK transition.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `irq`=0, `apbs_prdata`=0 when not selected, RX=0.
- APB accesses are zero-wait. Reads are combinational from registered state.
- The TX write access phase is cycle 0. BUSY and CS assertion are visible from cycle 1.
- Total BUSY duration is 18·H cycles. DONE and RX update on cycle 18·H+1; BUSY clears on the same cycle.
- At H=1, SCK runs at clk/2.
- If a DONE W1C and DONE set occur in the same cycle, the set wins.
- A TX write in the same cycle BUSY falls is ignored. BUSY is still 1 in that cycle.
- `spi_mosi` holds the last shifted bit after completion and is not returned to 0.
- Asynchronous reset mid-transfer returns all outputs to reset values immediately. No partial byte is reported.

## Structure
- Register offsets and field bit positions are shared with software headers via the register-generator output.
- FSM state encodings are localparams internal to the block.
- One sub-module: `spi_host_regs`, generated APB register block in the same style as the other peripherals' register blocks. The FSM, divider counter and shift register live in `spi_host`.

## Test plan
- Mode 0, DIV=1, TX=0xA5, MISO model returns 0x3C:
  - MOSI shows 1,0,1,0,0,1,0,1 on rising SCK.
  - RX=0x3C; BUSY high for exactly 18 cycles; DONE=1.
- Mode 3 (CPOL=1, CPHA=1), DIV=4, TX=0xFF, loopback MISO=MOSI:
  - SCK idles high; each half-period is 4 cycles.
  - RX=0xFF.
- CSAUTO=0, CS=1, two back-to-back transfers:
  - `spi_cs_n` stays 0 throughout, including between bytes.
  - Clearing CS drives `spi_cs_n` high next cycle.
- TX write and DIV write while BUSY:
  - Both ignored; the original byte completes; DIV unchanged.
- IRQ_EN=1:
  - `irq` rises with DONE; W1C to DONE drops it next cycle.
  - DONE set coincident with W1C leaves DONE=1.
- Assert `rst_n` mid-SHIFT:
  - `spi_cs_n`=1, `spi_sck`=0, BUSY=0 immediately.
  - A new transfer after release behaves normally.
